frame_tx_8b10b: RTL and testbench
=================================

FRAME_TX_8B10B -- requirements
Module: frame_tx_8b10b

Interface
REQ-001 Parameter IDLE_K, default 8'hBC (K28.5), is the inter-frame idle symbol.
REQ-002 Parameter SOP_K, default 8'hFB (K27.7), is the start-of-frame symbol.
REQ-003 Parameter EOP_K, default 8'hFD (K29.7), is the end-of-frame symbol.
REQ-004 Parameter FILL_K, default 8'h1C (K28.0), is the in-frame underrun filler.
REQ-005 Parameter MIN_IDLE, default 2, range 1-15, is the minimum number of IDLE_K symbols between frames.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock for all state.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 sym_adv  in  1  symbol slot strobe: exactly one symbol is emitted per cycle with sym_adv=1.
REQ-010 in_valid  in  1  payload byte present.
REQ-011 in_data  in  8  payload byte.
REQ-012 in_sop  in  1  byte is first of frame.
REQ-013 in_eop  in  1  byte is last of frame.
REQ-014 in_ready  out  1  combinational; byte accepted in any cycle where in_valid & in_ready.
REQ-015 enc_dat  out  8  registered symbol to encoder data input.
REQ-016 enc_k  out  1  registered; symbol is a K code (drives encoder K enable).
REQ-017 enc_ena  out  1  registered; symbol is a data byte (drives encoder data enable).
REQ-018 underrun  out  1  registered one-cycle pulse when FILL_K is emitted.
REQ-019 frame_cnt  out  16  frames completed (EOP_K emitted), wraps 16'hFFFF->0.
REQ-020 drop_cnt  out  8  bytes discarded outside a frame, saturates at 8'hFF.

Function
REQ-021 The block SHALL implement states IDLE, DATA, EOP; state changes only in cycles with sym_adv=1.
REQ-022 Every sym_adv cycle SHALL register exactly one symbol: enc_k=1,enc_ena=0 for K codes; enc_k=0,enc_ena=1 for data; latency 1 cycle from sym_adv to enc_* asserted.
REQ-023 In cycles with sym_adv=0, enc_k, enc_ena and underrun SHALL be 0 next cycle; enc_dat holds.
REQ-024 IDLE, sym_adv, idle_cnt>=MIN_IDLE, in_valid & in_sop: emit SOP_K, clear idle_cnt, go DATA; byte not consumed (in_ready=0).
REQ-025 IDLE, sym_adv, otherwise: emit IDLE_K, idle_cnt increments saturating at MIN_IDLE.
REQ-026 IDLE, in_valid & !in_sop & sym_adv: in_ready=1, byte discarded, drop_cnt increments (saturating).
REQ-027 DATA: in_ready = sym_adv.
REQ-028 DATA, sym_adv & in_valid: emit in_data as data; if in_eop go EOP, else stay DATA.
REQ-029 DATA, sym_adv & !in_valid: emit FILL_K, pulse underrun, stay DATA.
REQ-030 DATA: in_sop on an accepted byte SHALL be ignored (byte sent as ordinary data).
REQ-031 EOP, sym_adv: emit EOP_K, increment frame_cnt, clear idle_cnt, go IDLE; in_ready=0.
REQ-032 Byte with in_sop & in_eop SHALL form a one-byte frame: SOP_K, byte, EOP_K.
REQ-033 Consecutive frames SHALL be separated by at least MIN_IDLE IDLE_K symbols.

Reset
REQ-034 rst_n=0 SHALL immediately force state IDLE, idle_cnt=0, enc_dat=0, enc_k=0, enc_ena=0, underrun=0, frame_cnt=0, drop_cnt=0.
REQ-035 Reset mid-frame SHALL abandon the frame with no EOP_K; after release, MIN_IDLE IDLE_K symbols precede any SOP_K.

Verification
REQ-036 sym_adv=1 always, MIN_IDLE=2, frame 8'h11,8'h22,8'h33 held valid from reset release -> enc_dat: BC,BC,FB,11,22,33,FD,BC,BC; frame_cnt=1.
REQ-037 Same frame, in_valid dropped for 2 slots after 8'h11 -> FB,11,1C,1C,22,33,FD; underrun pulses twice.
REQ-038 sym_adv every 3rd cycle, single byte 8'hA5 with sop&eop -> enc_k/enc_ena pulse only the cycle after each sym_adv; sequence BC,BC,FB,A5,FD.
REQ-039 300 bytes without in_sop while in IDLE -> all accepted and discarded, only BC emitted, drop_cnt=8'hFF.
REQ-040 rst_n low after 2 data bytes, released, frame resent -> outputs 0 during reset, then BC,BC,FB,...; frame_cnt counts only completed frame.
REQ-041 Two back-to-back frames, second sop valid immediately after first eop -> exactly 2 BC between FD and FB; 65536 frames wrap frame_cnt to 0.

Source files
------------

// File: rtl/frame_tx_8b10b.sv
// Frame transmitter feeding an 8b10b encoder.
// Wraps payload bytes into SOP_K ... EOP_K frames, pads in-frame gaps with
// FILL_K, and keeps at least MIN_IDLE IDLE_K symbols between frames.
// Exactly one symbol is produced per sym_adv slot.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | between frames: emit IDLE_K, discard stray bytes, wait for SOP
// ST_DATA  | inside a frame: emit payload bytes, FILL_K on underrun
// ST_EOP   | last byte sent: emit EOP_K next slot, then back to ST_IDLE
module frame_tx_8b10b #(
  parameter logic [7:0]  IDLE_K   = 8'hBC,
  parameter logic [7:0]  SOP_K    = 8'hFB,
  parameter logic [7:0]  EOP_K    = 8'hFD,
  parameter logic [7:0]  FILL_K   = 8'h1C,
  parameter int unsigned MIN_IDLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sym_adv,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_ready,
  output logic [7:0]  enc_dat,
  output logic        enc_k,
  output logic        enc_ena,
  output logic        underrun,
  output logic [15:0] frame_cnt,
  output logic [7:0]  drop_cnt
);

  localparam logic [3:0] MIN_IDLE_C = 4'(MIN_IDLE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_EOP  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] idle_cnt;
  logic [3:0] idle_cnt_nxt;

  logic [7:0] sym_nxt;
  logic       sym_is_k;
  logic       fill_evt;
  logic       frame_done;
  logic       drop_evt;

  // Next-state, symbol selection and input handshake for the current slot.
  // The symbol fields only matter when sym_adv=1; otherwise they are ignored.
  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    sym_nxt      = IDLE_K;
    sym_is_k     = 1'b1;
    fill_evt     = 1'b0;
    frame_done   = 1'b0;
    drop_evt     = 1'b0;
    in_ready     = 1'b0;

    case (state)
      ST_IDLE: begin
        // Bytes arriving outside a frame are swallowed so the source never stalls.
        if (in_valid && !in_sop && sym_adv) begin
          in_ready = 1'b1;
          drop_evt = 1'b1;
        end
        if (sym_adv) begin
          if ((idle_cnt >= MIN_IDLE_C) && in_valid && in_sop) begin
            // The SOP byte itself stays at the input; it goes out next slot.
            sym_nxt      = SOP_K;
            idle_cnt_nxt = 4'd0;
            state_nxt    = ST_DATA;
          end else begin
            sym_nxt = IDLE_K;
            if (idle_cnt < MIN_IDLE_C) begin
              idle_cnt_nxt = idle_cnt + 4'd1;
            end
          end
        end
      end

      ST_DATA: begin
        in_ready = sym_adv;
        if (sym_adv) begin
          if (in_valid) begin
            // in_sop is deliberately ignored here: a second SOP inside a frame is just data.
            sym_nxt  = in_data;
            sym_is_k = 1'b0;
            if (in_eop) begin
              state_nxt = ST_EOP;
            end
          end else begin
            sym_nxt  = FILL_K;
            fill_evt = 1'b1;
          end
        end
      end

      ST_EOP: begin
        if (sym_adv) begin
          sym_nxt      = EOP_K;
          frame_done   = 1'b1;
          idle_cnt_nxt = 4'd0;
          state_nxt    = ST_IDLE;
        end
      end

      default: begin
        state_nxt    = ST_IDLE;
        idle_cnt_nxt = 4'd0;
      end
    endcase
  end

  // State register and inter-frame idle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idle_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

  // Encoder-facing symbol register; strobes are cleared in slots without sym_adv.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_dat  <= 8'h00;
      enc_k    <= 1'b0;
      enc_ena  <= 1'b0;
      underrun <= 1'b0;
    end else if (sym_adv) begin
      enc_dat  <= sym_nxt;
      enc_k    <= sym_is_k;
      enc_ena  <= !sym_is_k;
      underrun <= fill_evt;
    end else begin
      enc_k    <= 1'b0;
      enc_ena  <= 1'b0;
      underrun <= 1'b0;
    end
  end

  // Completed-frame counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 16'h0000;
    end else if (frame_done) begin
      frame_cnt <= frame_cnt + 16'h0001;
    end
  end

  // Discarded-byte counter, saturates so it stays a sticky indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'h00;
    end else if (drop_evt && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'h01;
    end
  end

endmodule

// File: tb/tb_frame_tx_8b10b.sv
// Scoreboard bench for frame_tx_8b10b: stimulus pushes hand-computed symbols,
// a forked monitor pops and compares every emitted symbol.
module tb_frame_tx_8b10b;

  localparam logic [7:0] BC = 8'hBC;
  localparam logic [7:0] FB = 8'hFB;
  localparam logic [7:0] FD = 8'hFD;
  localparam logic [7:0] FL = 8'h1C;

  logic        clk;
  logic        rst_n;
  logic        sym_adv;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_sop;
  logic        in_eop;
  logic        in_ready;
  logic [7:0]  enc_dat;
  logic        enc_k;
  logic        enc_ena;
  logic        underrun;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;

  typedef struct packed {
    logic       k;
    logic [7:0] d;
    logic       u;
  } sym_t;

  sym_t exp_q[$];
  int   tests;
  int   errs;
  int   und_seen;
  bit   mon_en;
  bit   div3;
  logic sa_q;

  frame_tx_8b10b #(
    .IDLE_K  (8'hBC),
    .SOP_K   (8'hFB),
    .EOP_K   (8'hFD),
    .FILL_K  (8'h1C),
    .MIN_IDLE(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sym_adv  (sym_adv),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_sop   (in_sop),
    .in_eop   (in_eop),
    .in_ready (in_ready),
    .enc_dat  (enc_dat),
    .enc_k    (enc_k),
    .enc_ena  (enc_ena),
    .underrun (underrun),
    .frame_cnt(frame_cnt),
    .drop_cnt (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Which slots were real symbol slots (reset slots never are).
  always @(posedge clk) sa_q <= sym_adv & rst_n;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic void ek(input logic [7:0] d);
    exp_q.push_back({1'b1, d, 1'b0});
  endfunction

  function automatic void ed(input logic [7:0] d);
    exp_q.push_back({1'b0, d, 1'b0});
  endfunction

  function automatic void ef();
    exp_q.push_back({1'b1, FL, 1'b1});
  endfunction

  task automatic monitor();
    logic [7:0] prev_dat;
    sym_t       e;
    prev_dat = 8'h00;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (sa_q) begin
          check("slot_flags", {31'd0, enc_k ^ enc_ena}, 32'd1);
          if (exp_q.size() == 0) begin
            tests++;
            errs++;
            $display("FAIL extra_symbol: got k=%0b dat=%h, expected no symbol", enc_k, enc_dat);
          end else begin
            e = exp_q.pop_front();
            check("symbol", {22'd0, enc_k, enc_dat, underrun}, {22'd0, e});
          end
        end else begin
          check("quiet_slot", {21'd0, enc_k, enc_ena, underrun, enc_dat}, {24'd0, prev_dat});
        end
        if (underrun) und_seen++;
      end
      prev_dat = enc_dat;
    end
  endtask

  task automatic sym_gen();
    int phase;
    phase = 0;
    sym_adv = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (div3) begin
        phase   = (phase == 2) ? 0 : phase + 1;
        sym_adv = (phase == 0);
      end else begin
        sym_adv = 1'b1;
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic s, input logic e);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    acc = 0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    if (!acc) begin
      tests++;
      errs++;
      $display("FAIL accept_timeout: byte %h not accepted within 200 cycles", d);
    end
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      errs++;
      $display("FAIL drain_timeout: %0d symbols still expected, expected 0", exp_q.size());
      exp_q.delete();
    end
    mon_en = 0;
  endtask

  task automatic hold_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int u0;
    int bad;
    rst_n    = 1'b0;
    sym_adv  = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    tests    = 0;
    errs     = 0;
    und_seen = 0;
    mon_en   = 0;
    div3     = 0;
    fork
      monitor();
      sym_gen();
      begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_enc_dat", {24'd0, enc_dat}, 32'h00);
    check("rst_flags", {29'd0, enc_k, enc_ena, underrun}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);

    // Basic three-byte frame held valid from reset release
    mon_en = 1;
    ek(BC); ek(BC); ek(FB); ed(8'h11); ed(8'h22); ed(8'h33); ek(FD); ek(BC); ek(BC);
    in_valid = 1'b1; in_data = 8'h11; in_sop = 1'b1;
    rst_n = 1'b1;
    push_byte(8'h11, 1'b1, 1'b0);
    push_byte(8'h22, 1'b0, 1'b0);
    push_byte(8'h33, 1'b0, 1'b1);
    wait_drain();
    check("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("t1_drop_cnt", {24'd0, drop_cnt}, 32'd0);

    // Underrun: two empty slots after the first byte
    hold_reset();
    mon_en = 1;
    u0 = und_seen;
    ek(BC); ek(BC); ek(FB); ed(8'h11); ef(); ef(); ed(8'h22); ed(8'h33); ek(FD);
    rst_n = 1'b1;
    push_byte(8'h11, 1'b1, 1'b0);
    gap(2);
    push_byte(8'h22, 1'b0, 1'b0);
    push_byte(8'h33, 1'b0, 1'b1);
    wait_drain();
    check("t2_underrun_pulses", und_seen - u0, 32'd2);
    check("t2_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // One-byte frame with a symbol slot every third cycle
    div3 = 1;
    hold_reset();
    mon_en = 1;
    ek(BC); ek(BC); ek(FB); ed(8'hA5); ek(FD);
    rst_n = 1'b1;
    push_byte(8'hA5, 1'b1, 1'b1);
    wait_drain();
    div3 = 0;
    check("t3_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // Stray bytes in IDLE are swallowed; drop counter saturates
    hold_reset();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      push_byte(8'(i), 1'b0, 1'b0);
      if (!(enc_k && !enc_ena && enc_dat == BC)) bad++;
      if (i == 253) check("t4_drop_cnt_254", {24'd0, drop_cnt}, 32'hFE);
    end
    check("t4_non_idle_symbols", bad, 32'd0);
    check("t4_drop_cnt_sat", {24'd0, drop_cnt}, 32'hFF);
    check("t4_frame_cnt", {16'd0, frame_cnt}, 32'd0);

    // Reset in the middle of a frame
    hold_reset();
    mon_en = 1;
    ek(BC); ek(BC); ek(FB); ed(8'hB0); ek(FD); ek(BC); ek(BC); ek(FB); ed(8'hC0); ed(8'hC1);
    rst_n = 1'b1;
    push_byte(8'hB0, 1'b1, 1'b1);
    push_byte(8'hC0, 1'b1, 1'b0);
    push_byte(8'hC1, 1'b0, 1'b0);
    wait_drain();
    check("t5_frame_cnt_before", {16'd0, frame_cnt}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_async_enc_dat", {24'd0, enc_dat}, 32'h00);
    check("t5_async_flags", {29'd0, enc_k, enc_ena, underrun}, 32'd0);
    check("t5_async_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_held_flags", {21'd0, enc_k, enc_ena, underrun, enc_dat}, 32'd0);
    mon_en = 1;
    ek(BC); ek(BC); ek(FB); ed(8'hC0); ed(8'hC1); ed(8'hC2); ek(FD);
    rst_n = 1'b1;
    push_byte(8'hC0, 1'b1, 1'b0);
    push_byte(8'hC1, 1'b0, 1'b0);
    push_byte(8'hC2, 1'b0, 1'b1);
    wait_drain();
    check("t5_frame_cnt_after", {16'd0, frame_cnt}, 32'd1);

    // Back-to-back frames; second frame carries a stray SOP mid-frame
    hold_reset();
    mon_en = 1;
    ek(BC); ek(BC); ek(FB); ed(8'hD0); ek(FD);
    ek(BC); ek(BC); ek(FB); ed(8'hE0); ed(8'hE1); ed(8'hE2); ek(FD); ek(BC); ek(BC);
    rst_n = 1'b1;
    push_byte(8'hD0, 1'b1, 1'b1);
    push_byte(8'hE0, 1'b1, 1'b0);
    push_byte(8'hE1, 1'b1, 1'b0);
    push_byte(8'hE2, 1'b0, 1'b1);
    wait_drain();
    check("t6_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    check("t6_drop_cnt", {24'd0, drop_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
